// File: rtl/fsm2_stepper.sv
// fsm2_stepper: transmit side of the single-wire edge-step protocol.
// Tracks the remote three-state sequencer (IDLE=00 -> S0=01 -> S1=10 -> IDLE)
// in a shadow register and emits the minimum number of clean pulses needed
// to land the remote sequencer on a requested target state.
module fsm2_stepper #(
   parameter int HIGH_CYC = 2,
   parameter int LOW_CYC  = 2,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] target,
   input  logic       clr,
   output logic       step_out,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] shadow
);

   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LOW_CYC - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   // At most two pulses are ever needed, so one bit says "one more after this".
   logic             rem, rem_nx;
   logic [1:0]       sh, sh_nx;
   logic             done_nx, err_nx;
   logic [2:0]       diff;
   logic [1:0]       n;

   // One step of the remote sequencer's state sequence.
   function automatic logic [1:0] adv(input logic [1:0] s);
      case (s)
         2'b00:   adv = 2'b01;
         2'b01:   adv = 2'b10;
         default: adv = 2'b00;
      endcase
   endfunction

   // Pulses needed: (target - shadow) mod 3, computed without a divider.
   always_comb begin
      diff = {1'b0, target} + 3'd3 - {1'b0, sh};
      n    = (diff >= 3'd3) ? 2'(diff - 3'd3) : diff[1:0];
   end

   // Next-state and next-output logic; clr overrides everything but reset.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rem_nx   = rem;
      sh_nx    = sh;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (clr) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         rem_nx   = 1'b0;
         sh_nx    = 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (target == 2'b11) begin
                     err_nx = 1'b1;
                  end else if (n == 2'd0) begin
                     done_nx = 1'b1;
                  end else begin
                     state_nx = HIGH;
                     cnt_nx   = '0;
                     rem_nx   = (n == 2'd2);
                     // Shadow moves on the same edge that raises step_out.
                     sh_nx    = adv(sh);
                  end
               end
            end
            HIGH: begin
               if (cnt == H_LAST) begin
                  state_nx = LOW;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            LOW: begin
               if (cnt == L_LAST) begin
                  cnt_nx = '0;
                  if (rem) begin
                     state_nx = HIGH;
                     rem_nx   = 1'b0;
                     sh_nx    = adv(sh);
                  end else begin
                     state_nx = IDLE;
                     done_nx  = 1'b1;
                  end
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
               rem_nx   = 1'b0;
            end
         endcase
      end
   end

   // State, counters, shadow and the one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= 1'b0;
         sh    <= 2'b00;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         rem   <= rem_nx;
         sh    <= sh_nx;
         done  <= done_nx;
         err   <= err_nx;
      end
   end

   assign step_out = (state == HIGH);
   assign busy     = (state != IDLE);
   assign shadow   = sh;

endmodule
